// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: synchronises the raw bus, deframes 11-bit frames and
// decodes E0/F0 prefixes into make events plus a held start-key level.
module ps2_key_receiver #(
  parameter logic [7:0]  START_CODE     = 8'h5A,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] last_key_received,
  output logic       key_extended,
  output logic       key_valid,
  output logic       start_key,
  output logic       frame_error
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t          state, next_state;
  logic            clk_s1, clk_s2, clk_prev;
  logic            dat_s1, dat_s2;
  logic            fall;
  logic [2:0]      count;
  logic [7:0]      shift;
  logic            parity;
  logic [TW-1:0]   tcount;
  logic            timed_out, byte_ready, frame_bad;
  logic            ext, brk;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
    end else begin
      clk_s1   <= PS2_CLK;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= PS2_DAT;
      dat_s2   <= dat_s1;
    end
  end

  assign fall = clk_prev & ~clk_s2;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // An edge always wins over the timeout, since the edge restarts the timer.
  always_comb begin
    next_state = state;
    byte_ready = 1'b0;
    frame_bad  = 1'b0;
    timed_out  = (state != IDLE) && !fall && (tcount == TW'(TIMEOUT_CYCLES));
    if (fall) begin
      case (state)
        IDLE:    if (!dat_s2) next_state = DATA;
        DATA:    if (count == 3'd7) next_state = PARITY;
        PARITY:  next_state = STOP;
        STOP: begin
          next_state = IDLE;
          if ((^shift ^ parity) && dat_s2) byte_ready = 1'b1;
          else                             frame_bad  = 1'b1;
        end
        default: next_state = IDLE;
      endcase
    end else if (timed_out) begin
      next_state = IDLE;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count  <= '0;
      shift  <= '0;
      parity <= 1'b0;
      tcount <= '0;
    end else begin
      if (fall || state == IDLE) tcount <= '0;
      else                       tcount <= tcount + 1'b1;
      if (fall) begin
        case (state)
          IDLE:    count <= '0;
          DATA: begin
            shift[count] <= dat_s2;
            count        <= count + 3'd1;
          end
          PARITY:  parity <= dat_s2;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_key_received <= '0;
      key_extended      <= 1'b0;
      key_valid         <= 1'b0;
      start_key         <= 1'b0;
      frame_error       <= 1'b0;
      ext               <= 1'b0;
      brk               <= 1'b0;
    end else begin
      key_valid   <= 1'b0;
      frame_error <= 1'b0;
      if (frame_bad || timed_out) begin
        frame_error <= 1'b1;
        ext         <= 1'b0;
        brk         <= 1'b0;
      end else if (byte_ready) begin
        if (shift == 8'hE0) begin
          ext <= 1'b1;
        end else if (shift == 8'hF0) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
          if (!brk) begin
            last_key_received <= shift;
            key_extended      <= ext;
            key_valid         <= 1'b1;
            if (shift == START_CODE && !ext) start_key <= 1'b1;
          end else if (shift == START_CODE && !ext) begin
            start_key <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Bench for ps2_key_receiver: directed scenarios followed by random frames,
// compared against a byte-level decoding model.
module tb_ps2_key_receiver;

  localparam int unsigned TO   = 100;
  localparam int unsigned HALF = 10;

  logic       clock = 1'b0;
  logic       reset;
  logic       PS2_CLK, PS2_DAT;
  logic [7:0] last_key_received;
  logic       key_extended, key_valid, start_key, frame_error;

  ps2_key_receiver #(.START_CODE(8'h5A), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT),
    .last_key_received(last_key_received), .key_extended(key_extended),
    .key_valid(key_valid), .start_key(start_key), .frame_error(frame_error)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc++;

  int kv_cnt = 0, fe_cnt = 0, both_cnt = 0, long_kv = 0;
  int unsigned last_kv_cyc = 0;
  logic kv_prev = 1'b0;
  always @(negedge clock) begin
    if (reset) begin
      kv_prev = 1'b0;
    end else begin
      if (key_valid) begin
        kv_cnt++;
        last_kv_cyc = cyc;
        if (kv_prev) long_kv++;
      end
      if (frame_error) fe_cnt++;
      if (key_valid && frame_error) both_cnt++;
      kv_prev = key_valid;
    end
  end

  // Reference model state
  logic [7:0] m_last;
  logic m_kext, m_start, m_ext, m_brk;
  int exp_kv = 0, exp_fe = 0;
  int vectors = 0, miscompares = 0;
  int unsigned stop_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int unsigned n);
    repeat (n) @(negedge clock);
  endtask

  task automatic ps2_bit(input logic b);
    PS2_DAT = b;
    wait_cyc(HALF);
    PS2_CLK = 1'b0;
    stop_cyc = cyc;
    wait_cyc(HALF);
    PS2_CLK = 1'b1;
  endtask

  task automatic model_reset();
    m_last = 8'h00; m_kext = 1'b0; m_start = 1'b0; m_ext = 1'b0; m_brk = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b, input logic good);
    if (!good) begin
      exp_fe++; m_ext = 1'b0; m_brk = 1'b0;
    end else if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      if (!m_brk) begin
        m_last = b; m_kext = m_ext; exp_kv++;
        if (b == 8'h5A && !m_ext) m_start = 1'b1;
      end else if (b == 8'h5A && !m_ext) m_start = 1'b0;
      m_ext = 1'b0; m_brk = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_kvcount"}, kv_cnt, exp_kv);
    check({tag, "_fecount"}, fe_cnt, exp_fe);
    check({tag, "_last"}, {24'h0, last_key_received}, {24'h0, m_last});
    check({tag, "_ext"}, {31'h0, key_extended}, {31'h0, m_kext});
    check({tag, "_start"}, {31'h0, start_key}, {31'h0, m_start});
  endtask

  task automatic send_frame(input string tag, input logic [7:0] b,
                            input logic bad_par, input logic bad_stop);
    logic make;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(~(^b) ^ bad_par);
    ps2_bit(~bad_stop);
    wait_cyc(30);
    make = !bad_par && !bad_stop && b != 8'hE0 && b != 8'hF0 && !m_brk;
    model_byte(b, !bad_par && !bad_stop);
    if (make) check({tag, "_latency"}, last_kv_cyc - stop_cyc, 3);
    check_all(tag);
  endtask

  task automatic send_partial(input logic [7:0] b, input int unsigned nbits);
    ps2_bit(1'b0);
    for (int unsigned i = 0; i < nbits; i++) ps2_bit(b[i]);
  endtask

  initial begin
    reset = 1'b1; PS2_CLK = 1'b1; PS2_DAT = 1'b1;
    model_reset();
    wait_cyc(5);
    check_all("reset");
    check("reset_kv", {31'h0, key_valid}, 0);
    check("reset_fe", {31'h0, frame_error}, 0);
    reset = 1'b0;
    wait_cyc(5);

    send_frame("w_make", 8'h1D, 1'b0, 1'b0);
    send_frame("enter_make", 8'h5A, 1'b0, 1'b0);
    send_frame("enter_repeat", 8'h5A, 1'b0, 1'b0);
    send_frame("brk_prefix", 8'hF0, 1'b0, 1'b0);
    send_frame("enter_break", 8'h5A, 1'b0, 1'b0);
    send_frame("ext_prefix", 8'hE0, 1'b0, 1'b0);
    send_frame("up_make", 8'h75, 1'b0, 1'b0);
    send_frame("ext_prefix2", 8'hE0, 1'b0, 1'b0);
    send_frame("ext_brk", 8'hF0, 1'b0, 1'b0);
    send_frame("up_break", 8'h75, 1'b0, 1'b0);
    send_frame("ext_enter_make", 8'hE0, 1'b0, 1'b0);
    send_frame("kp_enter", 8'h5A, 1'b0, 1'b0);
    send_frame("bad_parity", 8'h1D, 1'b1, 1'b0);
    send_frame("ext_then_bad", 8'hE0, 1'b0, 1'b0);
    send_frame("bad_stop", 8'h1D, 1'b0, 1'b1);
    send_frame("after_bad", 8'h2B, 1'b0, 1'b0);

    send_frame("to_prefix", 8'hE0, 1'b0, 1'b0);
    send_partial(8'h33, 5);
    wait_cyc(TO + 30);
    model_byte(8'h00, 1'b0);
    check_all("timeout");
    send_frame("after_timeout", 8'h1C, 1'b0, 1'b0);

    send_frame("pre_reset", 8'h5A, 1'b0, 1'b0);
    send_partial(8'h5A, 4);
    PS2_DAT = 1'b1;
    wait_cyc(HALF / 2);
    reset = 1'b1;
    wait_cyc(3);
    model_reset();
    check_all("midframe_reset");
    PS2_CLK = 1'b1;
    wait_cyc(5);
    reset = 1'b0;
    wait_cyc(5);
    send_frame("post_reset", 8'h5A, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      logic [7:0] b;
      logic bp, bs;
      int unsigned r;
      r = $urandom_range(0, 9);
      case (r)
        0: b = 8'hE0;
        1: b = 8'hF0;
        2: b = 8'h5A;
        3: b = 8'h1D;
        default: b = 8'($urandom);
      endcase
      bp = 1'b0; bs = 1'b0;
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 0) bp = 1'b1;
        else                           bs = 1'b1;
      end
      send_frame("random", b, bp, bs);
    end

    check("kv_fe_overlap", both_cnt, 0);
    check("kv_width", long_kv, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ps2_key_receiver.md
PS2_KEY_RECEIVER -- requirements
Module: ps2_key_receiver

Interface
REQ-001 SHALL have parameter START_CODE, default 8'h5A, the scan code that drives start_key (Enter).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000, the maximum clock cycles allowed between PS/2 falling edges inside a frame.
REQ-003 clock  input  1  system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 PS2_CLK  input  1  raw keyboard clock, asynchronous to clock.
REQ-006 PS2_DAT  input  1  raw keyboard data, asynchronous to clock.
REQ-007 last_key_received  output  8  most recent make-code byte, held until the next make.
REQ-008 key_extended  output  1  1 when last_key_received was preceded by E0.
REQ-009 key_valid  output  1  one-cycle pulse when last_key_received/key_extended update.
REQ-010 start_key  output  1  level, high while START_CODE (non-extended) is held down.
REQ-011 frame_error  output  1  one-cycle pulse on a discarded frame.

Function
REQ-012 SHALL pass PS2_CLK and PS2_DAT through 2-flop synchronizers, plus one further register on the synced clock for edge detection.
REQ-013 SHALL detect a PS/2 falling edge as previous synced clock = 1 and current = 0; all PS/2 bit sampling uses synced data in that cycle only.
REQ-014 Frame = start(0), 8 data bits LSB first, odd parity, stop(1); 11 falling edges.
REQ-015 FSM states: IDLE, DATA, PARITY, STOP.
REQ-016 IDLE: on an edge with data=0, go to DATA with bit count 0; with data=1, stay in IDLE with no error.
REQ-017 DATA: each edge shifts data into bit[count]; after the 8th bit, go to PARITY.
REQ-018 PARITY: on an edge, store the parity bit and go to STOP.
REQ-019 STOP: on an edge, check that the XOR of the 8 data bits and parity is 1 and that stop = 1; return to IDLE.
REQ-020 A good frame SHALL yield its byte to the decoder in the same cycle as the stop edge; the decoder's outputs register on the next rising edge (1-cycle latency from stop-edge detection).
REQ-021 On parity or stop failure: byte discarded, frame_error pulses for 1 cycle, E0/F0 prefix flags cleared.
REQ-022 A timeout counter SHALL clear on every edge and increment in non-IDLE states.
REQ-023 When the timeout counter reaches TIMEOUT_CYCLES in a non-IDLE state: return to IDLE, pulse frame_error, clear prefix flags.
REQ-024 Decoder, byte E0: set ext flag; no output change.
REQ-025 Decoder, byte F0: set brk flag; no output change.
REQ-026 Decoder, any other byte with brk=0 (make): last_key_received <= byte, key_extended <= ext, key_valid pulse; then clear ext and brk.
REQ-027 Decoder, any other byte with brk=1 (break): no key_valid; clear ext and brk.
REQ-028 start_key SHALL set on a make of START_CODE with ext=0 and clear on a break of START_CODE with ext=0; extended codes never affect it.
REQ-029 Typematic repeat (repeated make of the same code) SHALL re-pulse key_valid each time; start_key stays 1.
REQ-030 key_valid and frame_error SHALL never be high in the same cycle.

Reset
REQ-031 Reset SHALL force: FSM to IDLE, count 0, timeout 0, ext/brk flags 0, synchronizers to 1 (bus idle).
REQ-032 Reset SHALL force outputs: last_key_received=8'h00, key_extended=0, key_valid=0, start_key=0, frame_error=0.
REQ-033 Reset asserted mid-frame SHALL abandon the partial frame; the first frame after deassertion decodes normally with no frame_error.

Verification
REQ-034 Frame 0x1D (W), parity 1 -> key_valid 1 cycle, last_key_received=8'h1D, key_extended=0, start_key=0.
REQ-035 Frames 5A, then F0, 5A -> start_key rises with the 5A key_valid and falls after the second 5A; no key_valid for the break.
REQ-036 Frames E0, 75 (up arrow) -> single key_valid, last_key_received=8'h75, key_extended=1; then E0, F0, 75 -> no pulse, flags cleared.
REQ-037 Frame 0x1D with parity bit 0 -> frame_error 1 cycle, last_key_received unchanged, no key_valid.
REQ-038 Stop after 5 data bits, wait TIMEOUT_CYCLES -> frame_error pulse, FSM IDLE; next valid 0x1C frame -> last_key_received=8'h1C.
REQ-039 Assert reset during bit 4 of a 0x5A frame, release, send 0x5A -> outputs reset values, then start_key=1, key_valid once.
